lsq_store_buffer: RTL
=====================

# lsq_store_buffer

Parametrised store queue and post-commit write buffer for the load-store unit. It holds stores in program order from allocation until they drain to the D-cache. Its byte-enable generation is generalised to multi-word blocks (BLOCK_WIDTH a multiple of 32). It provides one registered, age-filtered store-to-load forwarding port.

## Interface
- ENTRY_NUM, 8, entry count; power of two, at least 2
- BLOCK_WIDTH, 64, entry data width in bits; a multiple of 32, at most 256
- ADDR_WIDTH, 32, physical address width
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- allocReq  in  1  allocate one entry at the tail
- allocReady  out  1  not full; an entry is allocated when allocReq && allocReady
- allocPtr  out  $clog2(ENTRY_NUM)  tail index, returned to the allocator
- wrValid  in  1  write the address and data of entry wrPtr
- wrPtr  in  $clog2(ENTRY_NUM)  entry to write
- wrAddr  in  ADDR_WIDTH  store byte address
- wrSize  in  2  0 byte, 1 half, 2 word, 3 block
- wrData  in  BLOCK_WIDTH  store data, right-aligned (LSB-first)
- commitValid  in  1  commit the oldest uncommitted entry
- flushValid  in  1  discard all uncommitted entries
- fwdValid  in  1  load lookup request
- fwdAddr / fwdSize  in  ADDR_WIDTH / 2  load address and size; same size encoding as wrSize
- fwdAgePtr  in  $clog2(ENTRY_NUM)+1  load's age tag: the tail position at load dispatch, including the wrap bit
- fwdHit  out  1  every requested byte is supplied by the buffer
- fwdConflict  out  1  the load must replay
- fwdData  out  BLOCK_WIDTH  forwarded data, right-aligned to fwdAddr
- dcWrValid  out  1  head store ready to write to the D-cache
- dcWrReady  in  1  D-cache accepts the write
- dcWrAddr / dcWrData / dcWrByteEn  out  ADDR_WIDTH / BLOCK_WIDTH / BLOCK_WIDTH/8  block-aligned write
- count  out  $clog2(ENTRY_NUM)+1  number of occupied entries

## Operation
- Pointers: head, commit and tail, each $clog2(ENTRY_NUM)+1 bits wide. The extra MSB is a wrap bit.
  - Full when tail−head == ENTRY_NUM. Empty when tail == head.
- Per-entry state: valid, written, committed, block address (ADDR_WIDTH−log2(BLOCK_WIDTH/8) bits), byte enable and block-aligned data.
- Write path:
  - Byte enable = size mask (1, 3, F, or all ones) << addr[log2(BLOCK_WIDTH/8)-1:0].
  - Data is shifted left by 8×byte offset.
  - Writes that cross a block boundary are illegal. The bench asserts they never occur.
- Commit:
  - Advances the commit pointer only when the entry at the commit pointer is written.
  - Otherwise commit is ignored and an assertion fires.
- Drain: dcWrValid = head entry committed. The head advances on dcWrValid && dcWrReady.
- Flush sets tail := commit. Committed entries are kept.
- Forwarding:
  - Candidate stores are written entries at positions [head, fwdAgePtr).
  - For each load byte, the youngest candidate whose block address matches and whose byte enable covers that byte supplies the data.
  - With all requested bytes covered: fwdHit=1, fwdConflict=0.
  - With no byte covered: fwdHit=0, fwdConflict=0, and the load reads the cache.
  - With some bytes covered: governed by the macro.
  - If any older candidate entry is still unwritten (address unknown): fwdConflict=1, fwdHit=0.
- Simultaneous events:
  - flush + alloc: flush wins and the alloc is dropped.
  - commit + flush: the commit applies first, then tail := the new commit pointer.
  - alloc + drain when full: no alloc, because allocReady is computed from the current count.
  - wrValid to an invalid entry: ignored.

## Timing
- Allocation, write, commit, flush and drain each take effect at the clock edge where they are asserted.
- allocReady and count reflect the state after that edge.
- Forwarding is a 1-cycle pipeline. Lookup with fwdValid in cycle N produces outputs in cycle N+1.
  - The lookup compares against state as of the start of cycle N. Same-cycle writes are not seen.
  - fwdHit and fwdConflict are 0 in any cycle after fwdValid=0.
- dcWr* outputs are driven from the head entry's registers. They are stable while dcWrValid && !dcWrReady.
- Reset, at an edge with rst_n=0:
  - All pointers and valid bits are cleared. This aborts a mid-operation drain.
  - Reset output values: allocReady=1, count=0, allocPtr=0, dcWrValid=0, fwdHit=0, fwdConflict=0, fwdData=0.

## Configuration
- RSD_STORE_BUFFER_PARTIAL_FORWARD_EN:
  - Defined: a partial byte match merges the covered bytes into fwdData with fwdHit=0, fwdConflict=0. fwdData is also driven whenever fwdHit=1. The load unit merges the uncovered bytes from the cache.
  - Undefined: any partial coverage sets fwdConflict=1 (replay), and fwdData is valid only when fwdHit=1.

## Structure
- Shared package LoadStoreUnitTypes holds:
  - the entry struct StoreBufferEntry;
  - the pointer types;
  - the size encoding;
  - the function that generates byte enables from address, size and block width.
- One sub-module, store_buffer_forward_select. It is purely combinational: it takes the per-entry match vectors and the age window, and produces the per-byte youngest-match one-hot plus the merged data.

## Test plan
- Full/wrap: alloc 8 with ENTRY_NUM=8 → allocReady=0, count=8. Write, commit and drain 1 → allocPtr=0 with wrap bit 1, and a ninth alloc succeeds.
- Byte forwarding: store word 0xAABBCCDD @0x1004, then load byte @0x1006 with fwdAgePtr past it → next cycle fwdHit=1, fwdData[7:0]=0xBB.
- Youngest wins: store word 0x11111111 @0x2000, then store byte 0x22 @0x2001. A load word @0x2000 → fwdData=0x11112211, fwdHit=1.
- Partial: store half 0x3344 @0x3000, then a load word @0x3000.
  - With the macro defined: fwdHit=0, fwdConflict=0, and fwdData[15:0]=0x3344.
  - Without the macro: fwdConflict=1.
- Flush: alloc 4, commit 2, flush → count=2, allocPtr=2. Drain with dcWrReady held low for 3 cycles → dcWrAddr/dcWrData stay stable, and the drain completes after ready rises.
- Reset mid-drain: rst_n=0 while dcWrValid=1 → next cycle dcWrValid=0, count=0, allocReady=1.

Source files
------------

// File: rtl/lsq_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// LoadStoreUnitTypes
// Shared types for the load-store unit store buffer:
//   MemAccessSize    - access size encoding (byte / half / word / block)
//   StoreBufferEntry - per-entry status flags (valid / written / committed)
//   genByteEnable    - size mask shifted to the byte offset inside a block
// Parameter-sized entry payload (block address, byte enable, data) lives in
// arrays inside lsq_store_buffer, because a package type cannot follow the
// module parameters.
// -----------------------------------------------------------------------------
package LoadStoreUnitTypes;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE  = 2'd0,
    MEM_SIZE_HALF  = 2'd1,
    MEM_SIZE_WORD  = 2'd2,
    MEM_SIZE_BLOCK = 2'd3
  } MemAccessSize;

  // Largest supported block is 256 bits = 32 bytes.
  localparam int unsigned MAX_BLOCK_BYTES = 32;
  typedef logic [MAX_BLOCK_BYTES-1:0] MaxByteEnable;

  typedef struct packed {
    logic valid;
    logic written;
    logic committed;
  } StoreBufferEntry;

  // Callers truncate the result to their own block byte count.
  function automatic MaxByteEnable genByteEnable(
    input logic [4:0]   offset,
    input MemAccessSize size,
    input int unsigned  blockBytes
  );
    logic [63:0] mask;
    case (size)
      MEM_SIZE_BYTE: mask = 64'h1;
      MEM_SIZE_HALF: mask = 64'h3;
      MEM_SIZE_WORD: mask = 64'hF;
      default:       mask = (64'h1 << blockBytes) - 64'h1;
    endcase
    return MaxByteEnable'(mask << offset);
  endfunction

endpackage

// File: rtl/lsq_store_buffer_forward_select.sv
// -----------------------------------------------------------------------------
// store_buffer_forward_select
// Combinational youngest-match selector for store-to-load forwarding.
//   headIdx     - index of the oldest entry (age order starts here)
//   inWindow    - entries inside the load's age window
//   addrMatch   - written entries whose block address matches the load
//   entryByteEn - per-entry byte enables
//   entryData   - per-entry block-aligned data
//   loadByteEn  - bytes requested by the load
//   byteSel     - per byte, one-hot of the youngest supplying entry
//   mergedData  - block-aligned data assembled from the selected entries
// -----------------------------------------------------------------------------
module store_buffer_forward_select #(
  parameter int ENTRY_NUM   = 8,
  parameter int BLOCK_WIDTH = 64
) (
  input  logic [$clog2(ENTRY_NUM)-1:0]                headIdx,
  input  logic [ENTRY_NUM-1:0]                        inWindow,
  input  logic [ENTRY_NUM-1:0]                        addrMatch,
  input  logic [ENTRY_NUM-1:0][BLOCK_WIDTH/8-1:0]     entryByteEn,
  input  logic [ENTRY_NUM-1:0][BLOCK_WIDTH-1:0]       entryData,
  input  logic [BLOCK_WIDTH/8-1:0]                    loadByteEn,
  output logic [BLOCK_WIDTH/8-1:0][ENTRY_NUM-1:0]     byteSel,
  output logic [BLOCK_WIDTH-1:0]                      mergedData
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int BB    = BLOCK_WIDTH / 8;

  logic [IDX_W-1:0] idx;

  always_comb begin
    byteSel    = '0;
    mergedData = '0;
    idx        = '0;
    for (int unsigned b = 0; b < BB; b++) begin
      // Walk from oldest to youngest; a later match overrides an earlier one.
      for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
        idx = IDX_W'(k) + headIdx;
        if (inWindow[idx] && addrMatch[idx] && entryByteEn[idx][b] && loadByteEn[b]) begin
          byteSel[b]      = '0;
          byteSel[b][idx] = 1'b1;
        end
      end
      for (int unsigned e = 0; e < ENTRY_NUM; e++) begin
        if (byteSel[b][e]) mergedData[8*b +: 8] = entryData[e][8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/lsq_store_buffer.sv
// -----------------------------------------------------------------------------
// lsq_store_buffer
// Store queue plus post-commit write buffer. Stores are held in program order
// from allocation until they drain to the D-cache. One registered, age-filtered
// store-to-load forwarding port.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   allocReq/allocReady/allocPtr   - tail allocation
//   wrValid/wrPtr/wrAddr/wrSize/wrData - address+data write of an entry
//   commitValid                    - commit oldest uncommitted entry
//   flushValid                     - discard uncommitted entries
//   fwdValid/fwdAddr/fwdSize/fwdAgePtr -> fwdHit/fwdConflict/fwdData (1 cycle)
//   dcWrValid/dcWrReady/dcWrAddr/dcWrData/dcWrByteEn - head drain to D-cache
//   count                          - occupied entries
// Build option: RSD_STORE_BUFFER_PARTIAL_FORWARD_EN - when defined, partially
// covered loads receive the covered bytes instead of replaying.
// -----------------------------------------------------------------------------
module lsq_store_buffer
  import LoadStoreUnitTypes::*;
#(
  parameter int ENTRY_NUM   = 8,
  parameter int BLOCK_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           allocReq,
  output logic                           allocReady,
  output logic [$clog2(ENTRY_NUM)-1:0]   allocPtr,
  input  logic                           wrValid,
  input  logic [$clog2(ENTRY_NUM)-1:0]   wrPtr,
  input  logic [ADDR_WIDTH-1:0]          wrAddr,
  input  logic [1:0]                     wrSize,
  input  logic [BLOCK_WIDTH-1:0]         wrData,
  input  logic                           commitValid,
  input  logic                           flushValid,
  input  logic                           fwdValid,
  input  logic [ADDR_WIDTH-1:0]          fwdAddr,
  input  logic [1:0]                     fwdSize,
  input  logic [$clog2(ENTRY_NUM):0]     fwdAgePtr,
  output logic                           fwdHit,
  output logic                           fwdConflict,
  output logic [BLOCK_WIDTH-1:0]         fwdData,
  output logic                           dcWrValid,
  input  logic                           dcWrReady,
  output logic [ADDR_WIDTH-1:0]          dcWrAddr,
  output logic [BLOCK_WIDTH-1:0]         dcWrData,
  output logic [BLOCK_WIDTH/8-1:0]       dcWrByteEn,
  output logic [$clog2(ENTRY_NUM):0]     count
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int PTR_W = IDX_W + 1;
  localparam int BB    = BLOCK_WIDTH / 8;
  localparam int OFF_W = $clog2(BB);
  localparam int BA_W  = ADDR_WIDTH - OFF_W;

  typedef logic [PTR_W-1:0] SbPtr;
  typedef logic [IDX_W-1:0] SbIdx;

  SbPtr headPtr, commitPtr, tailPtr, commitNext, occupancy, ageSpan;
  SbIdx headIdx, commitIdx, tailIdx, relAge;

  StoreBufferEntry                        entries [ENTRY_NUM];
  logic [ENTRY_NUM-1:0][BA_W-1:0]         entryBlockAddr;
  logic [ENTRY_NUM-1:0][BB-1:0]           entryByteEn;
  logic [ENTRY_NUM-1:0][BLOCK_WIDTH-1:0]  entryData;

  logic allocFire, writeFire, commitOk, commitFire, drainFire;

  assign headIdx   = headPtr[IDX_W-1:0];
  assign commitIdx = commitPtr[IDX_W-1:0];
  assign tailIdx   = tailPtr[IDX_W-1:0];

  assign occupancy  = tailPtr - headPtr;
  assign count      = occupancy;
  assign allocReady = (occupancy != SbPtr'(ENTRY_NUM));
  assign allocPtr   = tailIdx;

  assign allocFire  = allocReq && allocReady && !flushValid;
  assign writeFire  = wrValid && entries[wrPtr].valid;
  assign commitOk   = (commitPtr != tailPtr) && entries[commitIdx].valid &&
                      entries[commitIdx].written;
  assign commitFire = commitValid && commitOk;
  assign commitNext = commitFire ? commitPtr + SbPtr'(1) : commitPtr;

  assign dcWrValid  = entries[headIdx].valid && entries[headIdx].committed;
  assign drainFire  = dcWrValid && dcWrReady;
  assign dcWrAddr   = {entryBlockAddr[headIdx], {OFF_W{1'b0}}};
  assign dcWrData   = entryData[headIdx];
  assign dcWrByteEn = entryByteEn[headIdx];

  // ---------------------------------------------------------------- write path
  logic [OFF_W-1:0]       wrOff;
  logic [BB-1:0]          wrByteEn;
  logic [BLOCK_WIDTH-1:0] wrDataAligned;

  assign wrOff         = wrAddr[OFF_W-1:0];
  assign wrByteEn      = BB'(genByteEnable(5'(wrOff), MemAccessSize'(wrSize), BB));
  assign wrDataAligned = wrData << {wrOff, 3'b000};

  // ------------------------------------------------------------ control state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      headPtr   <= '0;
      commitPtr <= '0;
      tailPtr   <= '0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) entries[i] <= '0;
    end else begin
      if (drainFire) begin
        headPtr          <= headPtr + SbPtr'(1);
        entries[headIdx] <= '0;
      end
      commitPtr <= commitNext;
      if (commitFire) entries[commitIdx].committed <= 1'b1;
      if (writeFire)  entries[wrPtr].written <= 1'b1;
      if (flushValid) begin
        // The entry committed this cycle survives the flush.
        tailPtr <= commitNext;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
          if (entries[i].valid && !entries[i].committed &&
              !(commitFire && SbIdx'(i) == commitIdx))
            entries[i].valid <= 1'b0;
        end
      end else if (allocFire) begin
        tailPtr          <= tailPtr + SbPtr'(1);
        entries[tailIdx] <= '{valid: 1'b1, written: 1'b0, committed: 1'b0};
      end
    end
  end

  // Payload needs no reset: it is only observed through valid/written flags.
  always_ff @(posedge clk) begin
    if (writeFire) begin
      entryBlockAddr[wrPtr] <= wrAddr[ADDR_WIDTH-1:OFF_W];
      entryByteEn[wrPtr]    <= wrByteEn;
      entryData[wrPtr]      <= wrDataAligned;
    end
  end

  // ---------------------------------------------------------------- forwarding
  logic [OFF_W-1:0]           fwdOff;
  logic [BB-1:0]              loadByteEn, covered;
  logic [ENTRY_NUM-1:0]       inWindow, addrMatch, pendingOlder;
  logic [BB-1:0][ENTRY_NUM-1:0] byteSel;
  logic [BLOCK_WIDTH-1:0]     mergedData;

  assign fwdOff     = fwdAddr[OFF_W-1:0];
  assign loadByteEn = BB'(genByteEnable(5'(fwdOff), MemAccessSize'(fwdSize), BB));
  // Distance from head to the load's tag; beyond ENTRY_NUM means the tag is
  // already older than head (all its stores drained), so the window is empty.
  assign ageSpan    = fwdAgePtr - headPtr;

  always_comb begin
    inWindow     = '0;
    addrMatch    = '0;
    pendingOlder = '0;
    relAge       = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      relAge          = SbIdx'(i) - headIdx;
      inWindow[i]     = entries[i].valid && (ageSpan <= SbPtr'(ENTRY_NUM)) &&
                        ({1'b0, relAge} < ageSpan);
      addrMatch[i]    = entries[i].written &&
                        (entryBlockAddr[i] == fwdAddr[ADDR_WIDTH-1:OFF_W]);
      pendingOlder[i] = inWindow[i] && !entries[i].written;
    end
  end

  store_buffer_forward_select #(
    .ENTRY_NUM  (ENTRY_NUM),
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) u_forwardSelect (
    .headIdx    (headIdx),
    .inWindow   (inWindow),
    .addrMatch  (addrMatch),
    .entryByteEn(entryByteEn),
    .entryData  (entryData),
    .loadByteEn (loadByteEn),
    .byteSel    (byteSel),
    .mergedData (mergedData)
  );

  always_comb begin
    covered = '0;
    for (int unsigned b = 0; b < BB; b++) covered[b] = |byteSel[b];
  end

  logic                   hitNext, conflictNext;
  logic [BLOCK_WIDTH-1:0] dataNext;

  always_comb begin
    hitNext      = 1'b0;
    conflictNext = 1'b0;
    dataNext     = '0;
    if (fwdValid) begin
      dataNext = mergedData >> {fwdOff, 3'b000};
      if (|pendingOlder) begin
        conflictNext = 1'b1;
      end else if (covered == loadByteEn) begin
        hitNext = 1'b1;
      end else if (covered != '0) begin
`ifdef RSD_STORE_BUFFER_PARTIAL_FORWARD_EN
        conflictNext = 1'b0;
`else
        conflictNext = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwdHit      <= 1'b0;
      fwdConflict <= 1'b0;
      fwdData     <= '0;
    end else begin
      fwdHit      <= hitNext;
      fwdConflict <= conflictNext;
      fwdData     <= dataNext;
    end
  end

  commitOnWritten: assert property (@(posedge clk) disable iff (!rst_n)
    commitValid |-> commitOk);

endmodule
